// File: rtl/board_referee.sv
// board_referee: N x N, K-in-a-row referee. Alternating agent/player moves
// arrive over a valid/ready handshake. Illegal moves are rejected. After each
// legal move a one-cycle combinational scan looks for a win or a draw, and the
// result is held until new_game is requested.
module board_referee #(
  parameter int N     = 3,
  parameter int K     = 3,
  parameter int FIRST = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          new_game,
  input  logic                          move_valid,
  input  logic [$clog2(N*N)-1:0]        move_idx,
  output logic                          move_ready,
  output logic                          move_accept,
  output logic                          move_reject,
  output logic [1:0]                    turn,
  output logic [2*N*N-1:0]              board,
  output logic [1:0]                    outcome,
  output logic                          outcome_valid
);

  localparam int IW    = $clog2(N*N);
  localparam int CELLS = N*N;
  localparam int CW    = $clog2(N*N+1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(CELLS);
  localparam logic [1:0]    FIRST_SIDE = (FIRST == 2) ? 2'b10 : 2'b01;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MOVE = 2'd1,
    CHECK     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [1:0]      cell_q [CELLS];
  logic [CW-1:0]   count_q;

  logic            in_range;
  logic [IW-1:0]   idx_safe;
  logic            legal;
  logic            win;

  logic            do_clear;
  logic            do_write;
  logic            do_reject;
  logic            do_toggle;
  logic            do_win;
  logic            do_draw;

  // Handshake legality: an out-of-range index is mapped to cell 0 before the
  // lookup, so the array is never read out of bounds.
  always_comb begin
    in_range = (32'(move_idx) < 32'(CELLS));
    idx_safe = in_range ? move_idx : '0;
    legal    = in_range && (cell_q[idx_safe] == 2'b00);
  end

  // Single-cycle scan of every run of K cells in all four directions,
  // matched against the side that just moved (turn has not toggled yet).
  always_comb begin
    logic line;
    win  = 1'b0;
    line = 1'b0;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (c + K <= N) begin
          line = 1'b1;
          for (int unsigned i = 0; i < K; i++)
            line = line & (cell_q[r*N + c + i] == turn);
          win = win | line;
        end
        if (r + K <= N) begin
          line = 1'b1;
          for (int unsigned i = 0; i < K; i++)
            line = line & (cell_q[(r + i)*N + c] == turn);
          win = win | line;
        end
        if ((r + K <= N) && (c + K <= N)) begin
          line = 1'b1;
          for (int unsigned i = 0; i < K; i++)
            line = line & (cell_q[(r + i)*N + c + i] == turn);
          win = win | line;
        end
        if ((r + K <= N) && (c + 1 >= K)) begin
          line = 1'b1;
          for (int unsigned i = 0; i < K; i++)
            line = line & (cell_q[(r + i)*N + c - i] == turn);
          win = win | line;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and datapath controls; enable low outranks new_game, which
  // outranks any handshake.
  always_comb begin
    state_n   = state;
    do_clear  = 1'b0;
    do_write  = 1'b0;
    do_reject = 1'b0;
    do_toggle = 1'b0;
    do_win    = 1'b0;
    do_draw   = 1'b0;
    if (!enable) begin
      state_n  = IDLE;
      do_clear = 1'b1;
    end else if (new_game && (state != IDLE)) begin
      state_n  = WAIT_MOVE;
      do_clear = 1'b1;
    end else begin
      case (state)
        IDLE: state_n = WAIT_MOVE;
        WAIT_MOVE: begin
          if (move_valid) begin
            if (legal) begin
              do_write = 1'b1;
              state_n  = CHECK;
            end else begin
              do_reject = 1'b1;
            end
          end
        end
        CHECK: begin
          if (win) begin
            do_win  = 1'b1;
            state_n = DONE;
          end else if (count_q == FULL_COUNT) begin
            do_draw = 1'b1;
            state_n = DONE;
          end else begin
            do_toggle = 1'b1;
            state_n   = WAIT_MOVE;
          end
        end
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Board, move count, turn, outcome and the one-cycle result pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cell_q      <= '{default: 2'b00};
      count_q     <= '0;
      turn        <= FIRST_SIDE;
      outcome     <= 2'b00;
      move_accept <= 1'b0;
      move_reject <= 1'b0;
    end else begin
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      if (do_clear) begin
        cell_q  <= '{default: 2'b00};
        count_q <= '0;
        turn    <= FIRST_SIDE;
        outcome <= 2'b00;
      end else begin
        if (do_write) begin
          cell_q[idx_safe] <= turn;
          count_q          <= count_q + 1'b1;
          move_accept      <= 1'b1;
        end
        if (do_reject) move_reject <= 1'b1;
        if (do_toggle) turn        <= ~turn;
        if (do_win)    outcome     <= turn;
        if (do_draw)   outcome     <= 2'b11;
      end
    end
  end

  // Flatten the cell array onto the board bus and decode status outputs.
  always_comb begin
    board = '0;
    for (int unsigned i = 0; i < CELLS; i++)
      board[2*i +: 2] = cell_q[i];
    move_ready    = (state == WAIT_MOVE);
    outcome_valid = (state == DONE);
  end

endmodule
